// File: rtl/swerv_types.sv
// Shared DCCM types and widths for the LSU DCCM requester (optional feature macro: RV_DCCM_WBUF_FWD_EN).
// Widths follow RV_DCCM_BITS / RV_DCCM_FDATA_WIDTH and fall back to a 64KB, 39-bit (32+7 ECC) DCCM.
`ifndef RV_DCCM_BITS
`define RV_DCCM_BITS 16
`endif
`ifndef RV_DCCM_FDATA_WIDTH
`define RV_DCCM_FDATA_WIDTH 39
`endif

package swerv_types;
   localparam int DCCM_ADDR_W     = `RV_DCCM_BITS;
   localparam int DCCM_DATA_W     = `RV_DCCM_FDATA_WIDTH;
   localparam int DCCM_WBUF_DEPTH = 4;

   typedef struct packed {
      logic [DCCM_ADDR_W-1:0] addr;
      logic [DCCM_DATA_W-1:0] data;
   } dccm_wbuf_entry_t;

   // Byte offset within the word is ignored when checking store/load overlap.
   function automatic logic word_match(input logic [DCCM_ADDR_W-1:0] a,
                                       input logic [DCCM_ADDR_W-1:0] b);
      return (a[DCCM_ADDR_W-1:2] == b[DCCM_ADDR_W-1:2]);
   endfunction
endpackage

// File: rtl/lsu_dccm_wbuf.sv
// DCCM store buffer: FIFO with wrap-bit pointers plus address compare against pending entries.
// With RV_DCCM_WBUF_FWD_EN it also returns the youngest matching entry's data for each half.
module lsu_dccm_wbuf
   import swerv_types::*;
#(
   parameter int DEPTH = DCCM_WBUF_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst_l,
   input  logic                   push,
   input  logic                   pop,
   input  dccm_wbuf_entry_t       push_entry,
   input  logic [DCCM_ADDR_W-1:0] cmp_addr_lo,
   input  logic [DCCM_ADDR_W-1:0] cmp_addr_hi,
   output logic                   full,
   output logic                   empty,
   output dccm_wbuf_entry_t       head_entry,
   output logic                   hit_lo,
   output logic                   hit_hi
`ifdef RV_DCCM_WBUF_FWD_EN
   ,
   output logic [DCCM_DATA_W-1:0] hit_data_lo,
   output logic [DCCM_DATA_W-1:0] hit_data_hi
`endif
);
   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    count_s;
   dccm_wbuf_entry_t mem_q [DEPTH];
   dccm_wbuf_entry_t mem_d [DEPTH];

   assign count_s    = wr_ptr_q - rd_ptr_q;
   assign full       = (wr_ptr_q[IW] != rd_ptr_q[IW]) && (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
   assign empty      = (wr_ptr_q == rd_ptr_q);
   assign head_entry = mem_q[rd_ptr_q[IW-1:0]];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q[IW-1:0]] = push_entry;
         wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
   end

   // Walk from head to tail so the last match seen is the youngest.
   always_comb begin
      logic [IW-1:0] idx;
      idx    = '0;
      hit_lo = 1'b0;
      hit_hi = 1'b0;
`ifdef RV_DCCM_WBUF_FWD_EN
      hit_data_lo = '0;
      hit_data_hi = '0;
`endif
      for (int k = 0; k < DEPTH; k++) begin
         idx = rd_ptr_q[IW-1:0] + IW'(k);
         if (PW'(k) < count_s) begin
            if (word_match(mem_q[idx].addr, cmp_addr_lo)) begin
               hit_lo = 1'b1;
`ifdef RV_DCCM_WBUF_FWD_EN
               hit_data_lo = mem_q[idx].data;
`endif
            end
            if (word_match(mem_q[idx].addr, cmp_addr_hi)) begin
               hit_hi = 1'b1;
`ifdef RV_DCCM_WBUF_FWD_EN
               hit_data_hi = mem_q[idx].data;
`endif
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end
endmodule

// File: rtl/lsu_dccm_req.sv
// DCCM port requester: arbitrates LSU reads against store-buffer drains on the single-ported DCCM.
// Build option RV_DCCM_WBUF_FWD_EN forwards pending store data to hazard reads instead of stalling.
module lsu_dccm_req
   import swerv_types::*;
#(
   parameter int WBUF_DEPTH = DCCM_WBUF_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst_l,
   input  logic                   lsu_freeze_dc3,
   input  logic                   rd_valid,
   output logic                   rd_ready,
   input  logic [DCCM_ADDR_W-1:0] rd_addr_lo,
   input  logic [DCCM_ADDR_W-1:0] rd_addr_hi,
   output logic                   rd_rsp_valid,
   output logic [DCCM_DATA_W-1:0] rd_rsp_data_lo,
   output logic [DCCM_DATA_W-1:0] rd_rsp_data_hi,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic [DCCM_ADDR_W-1:0] wr_addr,
   input  logic [DCCM_DATA_W-1:0] wr_data,
   output logic                   wbuf_empty,
   output logic                   dccm_wren,
   output logic                   dccm_rden,
   output logic [DCCM_ADDR_W-1:0] dccm_wr_addr,
   output logic [DCCM_ADDR_W-1:0] dccm_rd_addr_lo,
   output logic [DCCM_ADDR_W-1:0] dccm_rd_addr_hi,
   output logic [DCCM_DATA_W-1:0] dccm_wr_data,
   input  logic [DCCM_DATA_W-1:0] dccm_rd_data_lo,
   input  logic [DCCM_DATA_W-1:0] dccm_rd_data_hi
);
   logic             full_s, empty_s, push_s, pop_s;
   logic             hit_lo_s, hit_hi_s, stall_hazard_s;
   logic             rsp_valid_q, rsp_valid_d;
   dccm_wbuf_entry_t push_entry_s, head_entry_s;

   assign wr_ready        = !full_s;
   assign push_s          = wr_valid && !full_s;
   assign wbuf_empty      = empty_s;
   assign push_entry_s    = '{addr: wr_addr, data: wr_data};
   assign dccm_wr_addr    = head_entry_s.addr;
   assign dccm_wr_data    = head_entry_s.data;
   assign dccm_rd_addr_lo = rd_addr_lo;
   assign dccm_rd_addr_hi = rd_addr_hi;
   assign rd_rsp_valid    = rsp_valid_q;

`ifdef RV_DCCM_WBUF_FWD_EN
   logic [DCCM_DATA_W-1:0] hit_data_lo_s, hit_data_hi_s;
`endif

   lsu_dccm_wbuf #(.DEPTH(WBUF_DEPTH)) u_wbuf (
      .clk         (clk),
      .rst_l       (rst_l),
      .push        (push_s),
      .pop         (pop_s),
      .push_entry  (push_entry_s),
      .cmp_addr_lo (rd_addr_lo),
      .cmp_addr_hi (rd_addr_hi),
      .full        (full_s),
      .empty       (empty_s),
      .head_entry  (head_entry_s),
      .hit_lo      (hit_lo_s),
      .hit_hi      (hit_hi_s)
`ifdef RV_DCCM_WBUF_FWD_EN
      ,
      .hit_data_lo (hit_data_lo_s),
      .hit_data_hi (hit_data_hi_s)
`endif
   );

   // Port arbitration: a full buffer must drain so a stalled hazard read always makes progress.
   always_comb begin
      rd_ready  = 1'b0;
      dccm_wren = 1'b0;
      dccm_rden = 1'b0;
      pop_s     = 1'b0;
      if (lsu_freeze_dc3) begin
         pop_s = 1'b0;
      end else if (full_s) begin
         pop_s     = 1'b1;
         dccm_wren = 1'b1;
      end else if (rd_valid && !stall_hazard_s) begin
         rd_ready  = 1'b1;
         dccm_rden = 1'b1;
      end else if (!empty_s) begin
         pop_s     = 1'b1;
         dccm_wren = 1'b1;
      end else begin
         pop_s = 1'b0;
      end
   end

   assign rsp_valid_d = rd_ready;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) rsp_valid_q <= 1'b0;
      else        rsp_valid_q <= rsp_valid_d;
   end

`ifdef RV_DCCM_WBUF_FWD_EN
   logic                   fwd_lo_sel_q, fwd_lo_sel_d, fwd_hi_sel_q, fwd_hi_sel_d;
   logic [DCCM_DATA_W-1:0] fwd_lo_data_q, fwd_lo_data_d, fwd_hi_data_q, fwd_hi_data_d;

   assign stall_hazard_s = 1'b0;

   // Capture forwarded data at accept; the compare sees the head even if it drains this cycle.
   always_comb begin
      fwd_lo_sel_d  = rd_ready && hit_lo_s;
      fwd_hi_sel_d  = rd_ready && hit_hi_s;
      fwd_lo_data_d = fwd_lo_data_q;
      fwd_hi_data_d = fwd_hi_data_q;
      if (rd_ready && hit_lo_s) fwd_lo_data_d = hit_data_lo_s;
      else                      fwd_lo_data_d = fwd_lo_data_q;
      if (rd_ready && hit_hi_s) fwd_hi_data_d = hit_data_hi_s;
      else                      fwd_hi_data_d = fwd_hi_data_q;
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         fwd_lo_sel_q  <= 1'b0;
         fwd_hi_sel_q  <= 1'b0;
         fwd_lo_data_q <= '0;
         fwd_hi_data_q <= '0;
      end else begin
         fwd_lo_sel_q  <= fwd_lo_sel_d;
         fwd_hi_sel_q  <= fwd_hi_sel_d;
         fwd_lo_data_q <= fwd_lo_data_d;
         fwd_hi_data_q <= fwd_hi_data_d;
      end
   end

   assign rd_rsp_data_lo = fwd_lo_sel_q ? fwd_lo_data_q : dccm_rd_data_lo;
   assign rd_rsp_data_hi = fwd_hi_sel_q ? fwd_hi_data_q : dccm_rd_data_hi;
`else
   assign stall_hazard_s = hit_lo_s || hit_hi_s;
   assign rd_rsp_data_lo = dccm_rd_data_lo;
   assign rd_rsp_data_hi = dccm_rd_data_hi;
`endif
endmodule

// File: tb/tb_lsu_dccm_req.sv
// Directed bench for lsu_dccm_req with a behavioural single-port DCCM macro model.
module tb_lsu_dccm_req;
   import swerv_types::*;
   localparam int AW = DCCM_ADDR_W;
   localparam int DW = DCCM_DATA_W;

   logic          clk = 1'b0;
   logic          rst_l, lsu_freeze_dc3, rd_valid, rd_ready, rd_rsp_valid;
   logic [AW-1:0] rd_addr_lo, rd_addr_hi, wr_addr, dccm_wr_addr, dccm_rd_addr_lo, dccm_rd_addr_hi;
   logic [DW-1:0] rd_rsp_data_lo, rd_rsp_data_hi, wr_data, dccm_wr_data;
   logic [DW-1:0] dccm_rd_data_lo, dccm_rd_data_hi;
   logic          wr_valid, wr_ready, wbuf_empty, dccm_wren, dccm_rden;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] mem [0:(1<<(AW-2))-1];

   always #5 clk = ~clk;

   lsu_dccm_req dut (
      .clk(clk), .rst_l(rst_l), .lsu_freeze_dc3(lsu_freeze_dc3),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr_lo(rd_addr_lo), .rd_addr_hi(rd_addr_hi),
      .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data_lo(rd_rsp_data_lo), .rd_rsp_data_hi(rd_rsp_data_hi),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .wbuf_empty(wbuf_empty), .dccm_wren(dccm_wren), .dccm_rden(dccm_rden),
      .dccm_wr_addr(dccm_wr_addr), .dccm_rd_addr_lo(dccm_rd_addr_lo), .dccm_rd_addr_hi(dccm_rd_addr_hi),
      .dccm_wr_data(dccm_wr_data), .dccm_rd_data_lo(dccm_rd_data_lo), .dccm_rd_data_hi(dccm_rd_data_hi)
   );

   // DCCM macro model: synchronous write, read data registered one cycle after rden.
   always @(posedge clk) begin
      if (dccm_wren) mem[dccm_wr_addr[AW-1:2]] <= dccm_wr_data;
      if (dccm_rden) begin
         dccm_rd_data_lo <= mem[dccm_rd_addr_lo[AW-1:2]];
         dccm_rd_data_hi <= mem[dccm_rd_addr_hi[AW-1:2]];
      end
   end

   task automatic idle_inputs;
      lsu_freeze_dc3 = 1'b0; rd_valid = 1'b0; wr_valid = 1'b0;
      rd_addr_lo = 16'h0000; rd_addr_hi = 16'h0000; wr_addr = 16'h0000; wr_data = '0;
   endtask

   task automatic do_reset;
      @(negedge clk); idle_inputs(); rst_l = 1'b0;
      @(negedge clk); @(negedge clk); rst_l = 1'b1;
   endtask

   task automatic test_reset;
      do_reset();
      #1;
      checks++; if (rd_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rd_rsp_valid); end
      checks++; if (wbuf_empty !== 1'b1) begin errors++; $display("FAIL reset_wbuf_empty got=%b exp=1", wbuf_empty); end
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
      checks++; if ({dccm_wren, dccm_rden} !== 2'b00) begin errors++; $display("FAIL reset_port got=%b exp=00", {dccm_wren, dccm_rden}); end
   endtask

   task automatic test_drain_order;
      logic [AW-1:0] a [3];
      logic [DW-1:0] d [3];
      a = '{16'h0100, 16'h0104, 16'h0108};
      d = '{39'h11_1111_1111, 39'h22_2222_2222, 39'h33_3333_3333};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         wr_valid = (i < 3); wr_addr = a[i % 3]; wr_data = d[i % 3];
         #1;
         checks++; if (dccm_wren !== (i >= 1 && i <= 3)) begin errors++; $display("FAIL drain_wren c%0d got=%b exp=%b", i, dccm_wren, (i >= 1 && i <= 3)); end
         if (i >= 1 && i <= 3) begin
            checks++; if (dccm_wr_addr !== a[i-1] || dccm_wr_data !== d[i-1]) begin errors++; $display("FAIL drain_entry c%0d got=%h/%h exp=%h/%h", i, dccm_wr_addr, dccm_wr_data, a[i-1], d[i-1]); end
         end
         checks++; if (dccm_rden !== 1'b0) begin errors++; $display("FAIL drain_rden c%0d got=%b exp=0", i, dccm_rden); end
      end
      checks++; if (wbuf_empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", wbuf_empty); end
      checks++; if (mem[16'h0104 >> 2] !== d[1]) begin errors++; $display("FAIL drain_mem got=%h exp=%h", mem[16'h0104 >> 2], d[1]); end
      idle_inputs();
   endtask

   task automatic test_hazard;
      logic [DW-1:0] d1;
      d1 = 39'h5A_DEAD_BEEF;
      do_reset();
      @(negedge clk); wr_valid = 1'b1; wr_addr = 16'h0200; wr_data = d1;
      @(negedge clk); wr_valid = 1'b0; rd_valid = 1'b1; rd_addr_lo = 16'h0202; rd_addr_hi = 16'h0280;
      #1;
`ifdef RV_DCCM_WBUF_FWD_EN
      checks++; if ({rd_ready, dccm_rden, dccm_wren} !== 3'b110) begin errors++; $display("FAIL fwd_accept got=%b exp=110", {rd_ready, dccm_rden, dccm_wren}); end
      @(negedge clk); rd_valid = 1'b0;
      #1;
      checks++; if (rd_rsp_valid !== 1'b1 || rd_rsp_data_lo !== d1) begin errors++; $display("FAIL fwd_rsp got=%b/%h exp=1/%h", rd_rsp_valid, rd_rsp_data_lo, d1); end
      checks++; if (rd_rsp_data_hi !== 39'h0) begin errors++; $display("FAIL fwd_rsp_hi got=%h exp=0", rd_rsp_data_hi); end
      checks++; if (dccm_wren !== 1'b1 || dccm_wr_addr !== 16'h0200) begin errors++; $display("FAIL fwd_drain got=%b/%h exp=1/0200", dccm_wren, dccm_wr_addr); end
      // Two stores to one word: the younger data must be forwarded.
      @(negedge clk); wr_valid = 1'b1; wr_addr = 16'h0208; wr_data = 39'h01_0000_0001;
      @(negedge clk); wr_addr = 16'h0208; wr_data = 39'h02_0000_0002; rd_valid = 1'b1; rd_addr_lo = 16'h0300; rd_addr_hi = 16'h0208;
      @(negedge clk); wr_valid = 1'b0; rd_valid = 1'b0;
      #1;
      checks++; if (rd_rsp_valid !== 1'b1 || rd_rsp_data_hi !== 39'h01_0000_0001) begin errors++; $display("FAIL fwd_order got=%b/%h exp=1/0100000001", rd_rsp_valid, rd_rsp_data_hi); end
      @(negedge clk); rd_valid = 1'b1; rd_addr_lo = 16'h0300; rd_addr_hi = 16'h0208;
      @(negedge clk); rd_valid = 1'b0;
      #1;
      checks++; if (rd_rsp_valid !== 1'b1 || rd_rsp_data_hi !== 39'h02_0000_0002) begin errors++; $display("FAIL fwd_youngest got=%b/%h exp=1/0200000002", rd_rsp_valid, rd_rsp_data_hi); end
`else
      checks++; if ({rd_ready, dccm_rden, dccm_wren} !== 3'b001) begin errors++; $display("FAIL haz_stall got=%b exp=001", {rd_ready, dccm_rden, dccm_wren}); end
      checks++; if (dccm_wr_addr !== 16'h0200) begin errors++; $display("FAIL haz_drain_addr got=%h exp=0200", dccm_wr_addr); end
      @(negedge clk);
      #1;
      checks++; if ({rd_ready, dccm_rden, dccm_wren} !== 3'b110) begin errors++; $display("FAIL haz_accept got=%b exp=110", {rd_ready, dccm_rden, dccm_wren}); end
      checks++; if (rd_rsp_valid !== 1'b0) begin errors++; $display("FAIL haz_early_rsp got=%b exp=0", rd_rsp_valid); end
      @(negedge clk); rd_valid = 1'b0;
      #1;
      checks++; if (rd_rsp_valid !== 1'b1 || rd_rsp_data_lo !== d1) begin errors++; $display("FAIL haz_rsp got=%b/%h exp=1/%h", rd_rsp_valid, rd_rsp_data_lo, d1); end
      checks++; if (rd_rsp_data_hi !== 39'h0) begin errors++; $display("FAIL haz_rsp_hi got=%h exp=0", rd_rsp_data_hi); end
`endif
      idle_inputs();
      repeat (4) @(negedge clk);
   endtask

   task automatic test_full;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         wr_valid = (i < 4); wr_addr = 16'h0400 + 16'(4 * (i % 4)); wr_data = 39'(i + 1);
         rd_valid = (i < 6); rd_addr_lo = 16'h0300; rd_addr_hi = 16'h0304;
         #1;
         checks++; if ((dccm_wren & dccm_rden) !== 1'b0) begin errors++; $display("FAIL full_both c%0d", i); end
         checks++; if (wr_ready !== (i != 4)) begin errors++; $display("FAIL full_wr_ready c%0d got=%b exp=%b", i, wr_ready, (i != 4)); end
         checks++; if (rd_ready !== (i < 4 || i == 5)) begin errors++; $display("FAIL full_rd_ready c%0d got=%b exp=%b", i, rd_ready, (i < 4 || i == 5)); end
         if (i == 4 || i >= 6) begin
            checks++; if (dccm_wren !== (i != 9) || (i != 9 && dccm_wr_addr !== 16'h0400 + 16'(4 * (i == 4 ? 0 : i - 5)))) begin
               errors++; $display("FAIL full_drain c%0d got=%b/%h", i, dccm_wren, dccm_wr_addr); end
         end
      end
      idle_inputs();
   endtask

   task automatic test_freeze;
      do_reset();
      @(negedge clk); wr_valid = 1'b1; wr_addr = 16'h0500; wr_data = 39'h0A;
      @(negedge clk); wr_addr = 16'h0504; wr_data = 39'h0B; lsu_freeze_dc3 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         wr_valid = (i == 0); wr_addr = 16'h0508; wr_data = 39'h0C;
         rd_valid = 1'b1; rd_addr_lo = 16'h0600; rd_addr_hi = 16'h0604;
         #1;
         checks++; if ({dccm_wren, dccm_rden, rd_ready} !== 3'b000) begin errors++; $display("FAIL freeze_gate c%0d got=%b exp=000", i, {dccm_wren, dccm_rden, rd_ready}); end
         if (i == 0) begin
            checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL freeze_wr_ready got=%b exp=1", wr_ready); end
         end
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); lsu_freeze_dc3 = 1'b0; rd_valid = 1'b0;
         #1;
         checks++; if (dccm_wren !== (i < 3) || (i < 3 && dccm_wr_addr !== 16'h0500 + 16'(4 * i))) begin
            errors++; $display("FAIL freeze_resume c%0d got=%b/%h exp=%b", i, dccm_wren, dccm_wr_addr, (i < 3)); end
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); wr_valid = 1'b1; wr_addr = 16'h0700 + 16'(4 * i); wr_data = 39'(i + 7);
         rd_valid = 1'b1; rd_addr_lo = 16'h0300; rd_addr_hi = 16'h0304;
      end
      @(negedge clk); idle_inputs();
      #1;
      checks++; if (rd_rsp_valid !== 1'b1 || wbuf_empty !== 1'b0) begin errors++; $display("FAIL mid_precond got=%b/%b exp=1/0", rd_rsp_valid, wbuf_empty); end
      rst_l = 1'b0;
      #1;
      checks++; if (rd_rsp_valid !== 1'b0 || wbuf_empty !== 1'b1 || wr_ready !== 1'b1) begin
         errors++; $display("FAIL mid_reset got=%b/%b/%b exp=0/1/1", rd_rsp_valid, wbuf_empty, wr_ready); end
      @(negedge clk); rst_l = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         checks++; if (dccm_wren !== 1'b0 || rd_rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_after c%0d got=%b/%b exp=0/0", i, dccm_wren, rd_rsp_valid); end
      end
   endtask

   initial begin
      for (int i = 0; i < (1 << (AW - 2)); i++) mem[i] = '0;
      dccm_rd_data_lo = '0; dccm_rd_data_hi = '0;
      rst_l = 1'b0;
      idle_inputs();
      test_reset();
      test_drain_order();
      test_hazard();
      test_full();
      test_freeze();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
